// File: rtl/tester_uart_pkg.sv
// Shared types for the tester-side UART arbitration logic.
package tester_uart_pkg;
  localparam int DATA_W_DEF = 6;

  typedef enum logic {IDLE, WAIT} arb_state_t;

  typedef logic [DATA_W_DEF-1:0] uart_char_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first request at or after ptr.
module rr_pick
  import tester_uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             vld
);
  logic [2*N_REQ-1:0] rot_dbl, back_dbl;
  logic [N_REQ-1:0]   rot, first;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_dbl  = {req, req} >> ptr;
    rot      = rot_dbl[N_REQ-1:0];
    first    = rot & (~rot + N_REQ'(1));
    back_dbl = {first, first} << ptr;
    gnt      = back_dbl[2*N_REQ-1:N_REQ];
    vld      = |req;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among N_REQ requesters, with a done watchdog.
module uart_tx_arbiter
  import tester_uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic [N_REQ-1:0]        in_req,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  output logic [N_REQ-1:0]        out_ack,
  output logic [N_REQ-1:0]        out_done,
  output logic                    out_timeout,
  output logic                    out_err,
  output logic                    out_tx_start,
  output logic [DATA_W-1:0]       out_tx_data,
  input  logic                    in_tx_busy,
  input  logic                    in_tx_done
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_t        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d, ack_q, ack_d, done_q, done_d;
  logic              tmo_q, tmo_d, err_q, err_d, start_q, start_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [N_REQ-1:0]  pick_gnt;
  logic              pick_vld;
  logic [PW-1:0]     pick_idx;
  logic [DATA_W-1:0] pick_data;

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req (in_req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .vld (pick_vld)
  );

  always_comb begin
    pick_idx  = '0;
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx  = PW'(i);
        pick_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    err_d   = err_q;
    ack_d   = '0;
    done_d  = '0;
    tmo_d   = 1'b0;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld && !in_tx_busy) begin
          data_d  = pick_data;
          start_d = 1'b1;
          ack_d   = pick_gnt;
          gnt_d   = pick_gnt;
          ptr_d   = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The start cycle is not counted, so expiry lands TIMEOUT_CYC+1 cycles after start.
        if (!start_q && cnt_q != '1) cnt_d = cnt_q + CW'(1);
        if (in_tx_done) begin
          done_d  = gnt_q;
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          tmo_d   = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

  assign out_ack      = ack_q;
  assign out_done     = done_q;
  assign out_timeout  = tmo_q;
  assign out_err      = err_q;
  assign out_tx_start = start_q;
  assign out_tx_data  = data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: a queue-based arbitration model predicts grants; a monitor checks DUT pulses.
module tb_uart_tx_arbiter;
  import tester_uart_pkg::*;

  localparam int N  = 4;
  localparam int W  = 6;
  localparam int TO = 16;

  logic           in_clk, in_rst;
  logic [N-1:0]   in_req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   out_ack, out_done;
  logic           out_timeout, out_err, out_tx_start;
  logic [W-1:0]   out_tx_data;
  logic           in_tx_busy, in_tx_done;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .in_clk       (in_clk),
    .in_rst       (in_rst),
    .in_req       (in_req),
    .in_data      (in_data),
    .out_ack      (out_ack),
    .out_done     (out_done),
    .out_timeout  (out_timeout),
    .out_err      (out_err),
    .out_tx_start (out_tx_start),
    .out_tx_data  (out_tx_data),
    .in_tx_busy   (in_tx_busy),
    .in_tx_done   (in_tx_done)
  );

  typedef struct {
    int         g;
    uart_char_t d;
    bit         chained;
    bit         want_done;
    int         at_cyc;
  } exp_t;

  uart_char_t rq    [N][$];
  uart_char_t stage [N][$];
  exp_t       exp_ack[$];
  int         exp_done[$];
  int         exp_tmo[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cyc = -100, start_cyc = -100, mptr = 0, ser_fix = 0;
  bit ser_stuck = 0, force_busy = 0, mon_en = 0, ser_busy = 0;

  assign in_tx_busy = ser_busy | force_busy;

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  always @(posedge in_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Model: each round favours the first requester with characters left at or after mptr.
  task automatic commit();
    int g;
    bit first;
    exp_t e;
    first = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < stage[i].size(); j++) rq[i].push_back(stage[i][j]);
    for (int n = 0; n < 64; n++) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && stage[(mptr + k) % N].size() != 0) g = (mptr + k) % N;
      if (g < 0) break;
      e.g = g;
      e.d = stage[g].pop_front();
      e.chained = !first && !ser_stuck;
      e.want_done = !ser_stuck;
      e.at_cyc = -1;
      exp_ack.push_back(e);
      first = 1'b0;
      mptr = (g + 1) % N;
    end
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_ack.size() != 0) || (exp_done.size() != 0) || (exp_tmo.size() != 0);
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string name);
    int t;
    t = 0;
    while (pending() && t < 400) begin
      @(negedge in_clk);
      t++;
    end
    chk({name, "_drain"}, (t < 400), 1);
    if (t >= 400) begin
      exp_ack.delete(); exp_done.delete(); exp_tmo.delete();
      for (int i = 0; i < N; i++) rq[i].delete();
    end
    repeat (2) @(negedge in_clk);
  endtask

  // Requesters hold req/data while characters remain, advancing on their ack.
  initial begin : requesters
    in_req = '0;
    in_data = '0;
    forever begin
      @(negedge in_clk);
      for (int i = 0; i < N; i++) begin
        if (out_ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        in_req[i] = (rq[i].size() != 0);
        if (rq[i].size() != 0) in_data[i*W +: W] = rq[i][0];
      end
    end
  end

  // Serializer stand-in: random latency, fixed latency, or never finishing.
  initial begin : serializer
    int cnt;
    cnt = 0;
    in_tx_done = 1'b0;
    forever begin
      @(negedge in_clk);
      in_tx_done = 1'b0;
      if (in_rst) begin
        ser_busy = 1'b0;
        cnt = 0;
      end else if (out_tx_start) begin
        if (ser_stuck) cnt = 0;
        else begin
          cnt = (ser_fix != 0) ? ser_fix : int'($urandom_range(1, 6));
          ser_busy = 1'b1;
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          in_tx_done = 1'b1;
          ser_busy = 1'b0;
          done_cyc = cyc;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int g;
    forever begin
      @(negedge in_clk);
      if (mon_en) begin
        if (out_ack != '0 || out_tx_start) begin
          if (exp_ack.size() == 0) chk("unexpected_grant", {out_ack, out_tx_start}, 0);
          else begin
            e = exp_ack.pop_front();
            chk("ack_onehot", out_ack, 32'd1 << e.g);
            chk("tx_start", out_tx_start, 1);
            chk("tx_data", out_tx_data, e.d);
            if (e.chained) chk("start_gap", cyc - done_cyc, 2);
            if (e.at_cyc >= 0) chk("busy_release_grant", cyc, e.at_cyc);
            start_cyc = cyc;
            if (e.want_done) exp_done.push_back(e.g);
            else exp_tmo.push_back(e.g);
          end
        end
        if (out_done != '0) begin
          if (exp_done.size() == 0) chk("unexpected_done", out_done, 0);
          else begin
            g = exp_done.pop_front();
            chk("done_onehot", out_done, 32'd1 << g);
            chk("done_latency", cyc - done_cyc, 1);
          end
        end
        if (out_timeout) begin
          if (exp_tmo.size() == 0) chk("unexpected_timeout", out_timeout, 0);
          else begin
            void'(exp_tmo.pop_front());
            chk("timeout_latency", cyc - start_cyc, TO + 1);
            chk("err_set", out_err, 1);
          end
        end
      end
    end
  end

  initial begin : stim
    int t, r;
    in_rst = 1'b1;
    repeat (3) @(negedge in_clk);
    chk("rst_ack", out_ack, 0);
    chk("rst_done", out_done, 0);
    chk("rst_timeout", out_timeout, 0);
    chk("rst_err", out_err, 0);
    chk("rst_start", out_tx_start, 0);
    chk("rst_data", out_tx_data, 0);
    in_rst = 1'b0;
    mon_en = 1'b1;
    @(negedge in_clk);

    // Fairness: all four requesting, requester 0 has a second character.
    for (int i = 0; i < N; i++) stage[i].push_back(uart_char_t'(10 + i));
    stage[0].push_back(uart_char_t'(10));
    commit();
    drain("fair");

    stage[0].push_back(6'b101010);
    commit();
    drain("single");

    // Wrap/skip: grant 2, then 0011 must go 0 then 1.
    stage[2].push_back(6'h15);
    commit();
    drain("wrap_a");
    stage[0].push_back(6'h21);
    stage[1].push_back(6'h22);
    commit();
    drain("wrap_b");

    // Busy gating.
    force_busy = 1'b1;
    stage[1].push_back(6'h2c);
    commit();
    repeat (4) @(negedge in_clk);
    chk("busy_holds_grant", exp_ack.size(), 1);
    force_busy = 1'b0;
    exp_ack[0].at_cyc = cyc + 1;
    drain("busy");

    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < N; i++)
        repeat ($urandom_range(0, 3)) stage[i].push_back(uart_char_t'($urandom_range(0, 63)));
      commit();
      drain("random");
    end

    // Watchdog with a serializer that never finishes.
    ser_stuck = 1'b1;
    r = int'($urandom_range(0, N - 1));
    stage[r].push_back(uart_char_t'($urandom_range(0, 63)));
    commit();
    drain("watchdog");
    ser_stuck = 1'b0;
    chk("err_sticky", out_err, 1);
    stage[(r + 1) % N].push_back(6'h07);
    stage[r].push_back(6'h38);
    commit();
    drain("after_watchdog");
    chk("err_still_sticky", out_err, 1);

    // Done arriving on the expiry cycle wins over the timeout.
    ser_fix = TO;
    stage[3].push_back(6'h1e);
    commit();
    drain("done_at_expiry");
    ser_fix = 0;

    // Reset in WAIT, with ptr left at 3 so a stale pointer would grant 3 first.
    ser_stuck = 1'b1;
    stage[2].push_back(6'h3f);
    commit();
    t = 0;
    while (exp_ack.size() != 0 && t < 50) begin
      @(negedge in_clk);
      t++;
    end
    chk("rst_mid_grant_seen", exp_ack.size(), 0);
    while (cyc < start_cyc + 5) @(negedge in_clk);
    mon_en = 1'b0;
    in_rst = 1'b1;
    #1;
    chk("rstmid_ack", out_ack, 0);
    chk("rstmid_done", out_done, 0);
    chk("rstmid_timeout", out_timeout, 0);
    chk("rstmid_err", out_err, 0);
    chk("rstmid_start", out_tx_start, 0);
    chk("rstmid_data", out_tx_data, 0);
    exp_ack.delete(); exp_done.delete(); exp_tmo.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    mptr = 0;
    ser_stuck = 1'b0;
    repeat (2) @(negedge in_clk);
    in_rst = 1'b0;
    mon_en = 1'b1;
    stage[1].push_back(6'h11);
    stage[3].push_back(6'h33);
    commit();
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
